cpu_step_4: RTL

// - Memory/branch-resolution stage; consumes execute-stage results (ALU out, zero flag, PC+1, PC+1+IMM, rdata2).
// - Drives data-memory req/ack port; registers writeback result for step 5; resolves conditional branch.
// - Variable-latency memory: stalls upstream until ack or timeout.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cpu_step_4_if.sv | 15 +
 rtl/mux.sv | 23 ++
 rtl/cpu_step_4.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline stages: memory-stage FSM states
// and default datapath / memory-timeout parameters.
package cpu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int WIDTH_DEF   = 32;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/cpu_step_4_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface cpu_step_4_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mux.sv
// Generic N-way selector over packed W-bit inputs; out-of-range selects
// yield zero.
module mux #(
  parameter int W = 32,
  parameter int N = 2,
  localparam int S = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][W-1:0] in_data,
  input  logic [S-1:0]        sel,
  output logic [W-1:0]        out_data
);

  // select the addressed input
  always_comb begin
    out_data = {W{1'b0}};
    if (32'(sel) < N) begin
      out_data = in_data[sel];
    end else begin
      out_data = {W{1'b0}};
    end
  end

endmodule

// File: rtl/cpu_step_4.sv
// Memory / branch-resolution stage: drives the data-memory bus, resolves
// beq-style branches and registers the writeback result for step 5.
module cpu_step_4
  import cpu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int ADDR_WIDTH = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_step_4,
  input  logic [WIDTH-1:0]      pc_plus_one_step_4,
  input  logic [WIDTH-1:0]      pc_plus_one_plus_IMM_step_4,
  input  logic [WIDTH-1:0]      out_alu_step_4,
  input  logic                  is_alu_zero_step_4,
  input  logic [WIDTH-1:0]      rdata2_step_4,
  input  logic [ADDR_WIDTH-1:0] rd_step_4,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch,
  input  logic                  reg_write,
  cpu_step_4_if.master          dmem,
  output logic                  stall_step_4,
  output logic                  branch_taken_step_4,
  output logic [WIDTH-1:0]      branch_target_step_4,
  output logic                  wb_valid_step_5,
  output logic                  wb_reg_write_step_5,
  output logic [WIDTH-1:0]      wb_data_step_5,
  output logic [ADDR_WIDTH-1:0] wb_rd_step_5,
  output logic                  mem_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    is_load_r;
  logic                    reg_write_r;
  logic [ADDR_WIDTH-1:0]   rd_r;

  logic                    mem_op_s;
  logic                    accept_mem_s;
  logic                    accept_alu_s;
  logic                    ack_s;
  logic                    timeout_s;
  logic                    take_s;
  logic                    wb_sel_s;
  logic [1:0][WIDTH-1:0]   wb_in_s;
  logic [WIDTH-1:0]        wb_data_s;
  logic                    unused_ok_s;

  assign mem_op_s     = mem_read | mem_write;
  assign accept_mem_s = (state_r == IDLE) & valid_step_4 & mem_op_s;
  assign accept_alu_s = (state_r == IDLE) & valid_step_4 & ~mem_op_s;
  assign ack_s        = (state_r == WAIT) & dmem.ack;
  assign timeout_s    = (state_r == WAIT) & ~dmem.ack & (cnt_r == CNT_LAST);
  assign take_s       = branch & is_alu_zero_step_4;
  assign unused_ok_s  = &{1'b0, pc_plus_one_step_4};

  // Upstream is held in the very cycle a memory op is presented, and throughout WAIT.
  assign stall_step_4 = ~rst & ((state_r == WAIT) | accept_mem_s);

  assign wb_sel_s   = (state_r == WAIT);
  assign wb_in_s[0] = out_alu_step_4;
  assign wb_in_s[1] = is_load_r ? dmem.rdata : {WIDTH{1'b0}};

  mux #(.W(WIDTH), .N(2)) u_wb_mux (
    .in_data  (wb_in_s),
    .sel      (wb_sel_s),
    .out_data (wb_data_s)
  );

  // FSM, timeout counter and memory-bus registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      is_load_r   <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= {ADDR_WIDTH{1'b0}};
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= {WIDTH{1'b0}};
      dmem.wdata  <= {WIDTH{1'b0}};
      mem_err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_mem_s) begin
            state_r     <= WAIT;
            cnt_r       <= {CNT_W{1'b0}};
            is_load_r   <= mem_read;
            reg_write_r <= reg_write;
            rd_r        <= rd_step_4;
            dmem.req    <= 1'b1;
            dmem.we     <= mem_write;
            dmem.addr   <= out_alu_step_4;
            dmem.wdata  <= rdata2_step_4;
          end else begin
            dmem.req <= 1'b0;
          end
        end
        WAIT: begin
          if (dmem.ack) begin
            state_r  <= IDLE;
            dmem.req <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= IDLE;
            dmem.req <= 1'b0;
            mem_err  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          dmem.req <= 1'b0;
        end
      endcase
    end
  end

  // Writeback / branch-result registers; valid and taken are one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_step_5      <= 1'b0;
      wb_reg_write_step_5  <= 1'b0;
      wb_data_step_5       <= {WIDTH{1'b0}};
      wb_rd_step_5         <= {ADDR_WIDTH{1'b0}};
      branch_taken_step_4  <= 1'b0;
      branch_target_step_4 <= {WIDTH{1'b0}};
    end else begin
      wb_valid_step_5     <= 1'b0;
      branch_taken_step_4 <= 1'b0;
      if (accept_alu_s) begin
        wb_valid_step_5     <= 1'b1;
        wb_data_step_5      <= wb_data_s;
        wb_rd_step_5        <= rd_step_4;
        wb_reg_write_step_5 <= reg_write & ~take_s;
        if (take_s) begin
          branch_taken_step_4  <= 1'b1;
          branch_target_step_4 <= pc_plus_one_plus_IMM_step_4;
        end
      end else if (ack_s) begin
        wb_valid_step_5     <= 1'b1;
        wb_data_step_5      <= wb_data_s;
        wb_rd_step_5        <= rd_r;
        wb_reg_write_step_5 <= is_load_r & reg_write_r;
      end else if (timeout_s) begin
        wb_valid_step_5     <= 1'b1;
        wb_data_step_5      <= {WIDTH{1'b0}};
        wb_rd_step_5        <= rd_r;
        wb_reg_write_step_5 <= 1'b0;
      end else begin
        wb_reg_write_step_5 <= 1'b0;
      end
    end
  end

endmodule
